// File: rtl/timer_regs_pkg.sv
// Shared constants for the timer register block: one-hot selects, bit positions,
// reset values and writable-bit masks.
package timer_regs_pkg;

   localparam logic [2:0] SEL_TDR = 3'b001;
   localparam logic [2:0] SEL_TCR = 3'b010;
   localparam logic [2:0] SEL_TSR = 3'b100;

   localparam int unsigned TCR_LOAD_BIT    = 7;
   localparam int unsigned TCR_UP_DOWN_BIT = 5;
   localparam int unsigned TCR_EN_BIT      = 4;
   localparam int unsigned TCR_CKS_LSB     = 0;

   localparam int unsigned TSR_OVF_BIT = 0;
   localparam int unsigned TSR_UDF_BIT = 1;

   localparam logic [7:0] TDR_RESET = 8'h00;
   localparam logic [7:0] TCR_RESET = 8'h00;
   localparam logic [7:0] TSR_RESET = 8'h00;

   // Bits 6, 3 and 2 of TCR are reserved and never stored.
   localparam logic [7:0] TCR_WRITE_MASK = 8'hB3;
   localparam logic [7:0] TSR_FLAG_MASK  = 8'h03;

endpackage

// File: rtl/timer_flag_bit.sv
// One sticky status flag: event sets, write-1 clears, set wins over clear.
// Clear pulse output is only generated when TSR_CLEAR_FLAG_PULSE_EN is defined.
module timer_flag_bit
   import timer_regs_pkg::*;
(
   input  logic tr_clk,
   input  logic tr_reset_n,
   input  logic set_evt,
   input  logic clr_req,
   output logic flag,
   output logic clear_pulse
);

   always_ff @(posedge tr_clk or negedge tr_reset_n) begin
      if (!tr_reset_n) begin
         flag <= 1'b0;
      end else if (set_evt) begin
         flag <= 1'b1;
      end else if (clr_req) begin
         flag <= 1'b0;
      end
   end

`ifdef TSR_CLEAR_FLAG_PULSE_EN
   always_ff @(posedge tr_clk or negedge tr_reset_n) begin
      if (!tr_reset_n) begin
         clear_pulse <= 1'b0;
      end else begin
         clear_pulse <= clr_req;
      end
   end
`else
   assign clear_pulse = 1'b0;
`endif

endmodule

// File: rtl/timer_regs.sv
// Timer register file (TDR, TCR, TSR) on an APB-style write strobe.
// Optional TSR_CLEAR_FLAG_PULSE_EN enables the registered per-flag clear pulse.
module timer_regs
   import timer_regs_pkg::*;
(
   input  logic       tr_clk,
   input  logic       tr_reset_n,
   input  logic       tr_sel,
   input  logic       tr_write,
   input  logic       tr_enable,
   input  logic [2:0] tr_selected_reg,
   input  logic [7:0] tr_wdata,
   input  logic       tr_ready,
   input  logic       tr_ovf_flag,
   input  logic       tr_udf_flag,
   output logic [7:0] tr_tdr_rdata,
   output logic [7:0] tr_tcr_rdata,
   output logic [7:0] tr_tsr_rdata,
   output logic       tr_tcr_load,
   output logic       tr_tcr_up_down,
   output logic       tr_tcr_en,
   output logic [1:0] tr_tcr_cks,
   output logic [1:0] tr_tsr_clear_flag
);

   logic       wr_go;
   logic       wr_tdr;
   logic       wr_tcr;
   logic       wr_tsr;
   logic [7:0] tdr_q;
   logic [7:0] tcr_q;
   logic       ovf_q;
   logic       udf_q;

   assign wr_go  = tr_sel & tr_write & tr_enable & tr_ready;
   // Exact compare, so non-one-hot selects decode to nothing.
   assign wr_tdr = wr_go & (tr_selected_reg == SEL_TDR);
   assign wr_tcr = wr_go & (tr_selected_reg == SEL_TCR);
   assign wr_tsr = wr_go & (tr_selected_reg == SEL_TSR);

   always_ff @(posedge tr_clk or negedge tr_reset_n) begin
      if (!tr_reset_n) begin
         tdr_q <= TDR_RESET;
      end else if (wr_tdr) begin
         tdr_q <= tr_wdata;
      end
   end

   always_ff @(posedge tr_clk or negedge tr_reset_n) begin
      if (!tr_reset_n) begin
         tcr_q <= TCR_RESET;
      end else if (wr_tcr) begin
         tcr_q <= tr_wdata & TCR_WRITE_MASK;
      end
   end

   timer_flag_bit u_ovf_flag (
      .tr_clk      (tr_clk),
      .tr_reset_n  (tr_reset_n),
      .set_evt     (tr_ovf_flag),
      .clr_req     (wr_tsr & tr_wdata[TSR_OVF_BIT]),
      .flag        (ovf_q),
      .clear_pulse (tr_tsr_clear_flag[TSR_OVF_BIT])
   );

   timer_flag_bit u_udf_flag (
      .tr_clk      (tr_clk),
      .tr_reset_n  (tr_reset_n),
      .set_evt     (tr_udf_flag),
      .clr_req     (wr_tsr & tr_wdata[TSR_UDF_BIT]),
      .flag        (udf_q),
      .clear_pulse (tr_tsr_clear_flag[TSR_UDF_BIT])
   );

   assign tr_tdr_rdata   = tdr_q;
   assign tr_tcr_rdata   = tcr_q;
   assign tr_tsr_rdata   = {6'b000000, udf_q, ovf_q} & TSR_FLAG_MASK;
   assign tr_tcr_load    = tcr_q[TCR_LOAD_BIT];
   assign tr_tcr_up_down = tcr_q[TCR_UP_DOWN_BIT];
   assign tr_tcr_en      = tcr_q[TCR_EN_BIT];
   assign tr_tcr_cks     = tcr_q[TCR_CKS_LSB +: 2];

endmodule

// File: tb/tb_timer_regs.sv
// Directed self-checking bench for timer_regs; expected clear pulses follow
// whether TSR_CLEAR_FLAG_PULSE_EN is defined for the build.
module tb_timer_regs;

`ifdef TSR_CLEAR_FLAG_PULSE_EN
   localparam logic PULSE_EN = 1'b1;
`else
   localparam logic PULSE_EN = 1'b0;
`endif

   logic       tr_clk;
   logic       tr_reset_n;
   logic       tr_sel;
   logic       tr_write;
   logic       tr_enable;
   logic [2:0] tr_selected_reg;
   logic [7:0] tr_wdata;
   logic       tr_ready;
   logic       tr_ovf_flag;
   logic       tr_udf_flag;
   logic [7:0] tr_tdr_rdata;
   logic [7:0] tr_tcr_rdata;
   logic [7:0] tr_tsr_rdata;
   logic       tr_tcr_load;
   logic       tr_tcr_up_down;
   logic       tr_tcr_en;
   logic [1:0] tr_tcr_cks;
   logic [1:0] tr_tsr_clear_flag;

   int n_checks = 0;
   int n_pass   = 0;

   timer_regs dut (
      .tr_clk            (tr_clk),
      .tr_reset_n        (tr_reset_n),
      .tr_sel            (tr_sel),
      .tr_write          (tr_write),
      .tr_enable         (tr_enable),
      .tr_selected_reg   (tr_selected_reg),
      .tr_wdata          (tr_wdata),
      .tr_ready          (tr_ready),
      .tr_ovf_flag       (tr_ovf_flag),
      .tr_udf_flag       (tr_udf_flag),
      .tr_tdr_rdata      (tr_tdr_rdata),
      .tr_tcr_rdata      (tr_tcr_rdata),
      .tr_tsr_rdata      (tr_tsr_rdata),
      .tr_tcr_load       (tr_tcr_load),
      .tr_tcr_up_down    (tr_tcr_up_down),
      .tr_tcr_en         (tr_tcr_en),
      .tr_tcr_cks        (tr_tcr_cks),
      .tr_tsr_clear_flag (tr_tsr_clear_flag)
   );

   initial tr_clk = 1'b0;
   always #5 tr_clk = ~tr_clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
   endtask

   task automatic bus_idle();
      tr_sel = 1'b0; tr_write = 1'b0; tr_enable = 1'b0; tr_ready = 1'b0;
      tr_selected_reg = 3'b000; tr_wdata = 8'h00;
      tr_ovf_flag = 1'b0; tr_udf_flag = 1'b0;
   endtask

   // One-cycle transfer; returns at the falling edge after the capturing edge.
   task automatic bus_xfer(input logic [2:0] sel_reg, input logic [7:0] data,
                           input logic wr, input logic rdy,
                           input logic ovf, input logic udf);
      @(negedge tr_clk);
      tr_sel = 1'b1; tr_write = wr; tr_enable = 1'b1; tr_ready = rdy;
      tr_selected_reg = sel_reg; tr_wdata = data;
      tr_ovf_flag = ovf; tr_udf_flag = udf;
      @(negedge tr_clk);
      bus_idle();
   endtask

   task automatic pulse_events(input logic ovf, input logic udf);
      @(negedge tr_clk);
      tr_ovf_flag = ovf; tr_udf_flag = udf;
      @(negedge tr_clk);
      bus_idle();
   endtask

   task automatic chk_all(input string tag, input logic [7:0] tdr,
                          input logic [7:0] tcr, input logic [7:0] tsr);
      chk({tag, "_tdr"}, tr_tdr_rdata, tdr);
      chk({tag, "_tcr"}, tr_tcr_rdata, tcr);
      chk({tag, "_tsr"}, tr_tsr_rdata, tsr);
   endtask

   initial begin
      bus_idle();
      tr_reset_n = 1'b0;
      repeat (3) @(negedge tr_clk);

      chk_all("rst", 8'h00, 8'h00, 8'h00);
      chk("rst_load", {7'd0, tr_tcr_load}, 8'h00);
      chk("rst_updown", {7'd0, tr_tcr_up_down}, 8'h00);
      chk("rst_en", {7'd0, tr_tcr_en}, 8'h00);
      chk("rst_cks", {6'd0, tr_tcr_cks}, 8'h00);
      chk("rst_clrflag", {6'd0, tr_tsr_clear_flag}, 8'h00);
      tr_reset_n = 1'b1;

      // TDR write, then blocked transfers
      bus_xfer(3'b001, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tdr_wr", tr_tdr_rdata, 8'hA5);
      bus_xfer(3'b001, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("tdr_noready", tr_tdr_rdata, 8'hA5);
      bus_xfer(3'b001, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("tdr_read_only", tr_tdr_rdata, 8'hA5);
      bus_xfer(3'b001, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tdr_wr2", tr_tdr_rdata, 8'h5A);

      // TCR masking and decoded outputs
      bus_xfer(3'b010, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tcr_ff", tr_tcr_rdata, 8'hB3);
      chk("tcr_ff_load", {7'd0, tr_tcr_load}, 8'h01);
      chk("tcr_ff_updown", {7'd0, tr_tcr_up_down}, 8'h01);
      chk("tcr_ff_en", {7'd0, tr_tcr_en}, 8'h01);
      chk("tcr_ff_cks", {6'd0, tr_tcr_cks}, 8'h03);
      bus_xfer(3'b010, 8'h4E, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tcr_4e", tr_tcr_rdata, 8'h02);
      chk("tcr_4e_load", {7'd0, tr_tcr_load}, 8'h00);
      chk("tcr_4e_cks", {6'd0, tr_tcr_cks}, 8'h02);
      bus_xfer(3'b010, 8'h91, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tcr_91_updown", {7'd0, tr_tcr_up_down}, 8'h00);
      chk("tcr_91_en", {7'd0, tr_tcr_en}, 8'h01);
      repeat (5) @(negedge tr_clk);
      chk("tcr_load_holds", {7'd0, tr_tcr_load}, 8'h01);
      chk("tcr_91", tr_tcr_rdata, 8'h91);

      // OVF sticky, then W1C with clear pulse
      pulse_events(1'b1, 1'b0);
      chk("ovf_set", tr_tsr_rdata, 8'h01);
      for (int i = 0; i < 10; i++) begin
         @(negedge tr_clk);
         chk("ovf_sticky", tr_tsr_rdata, 8'h01);
      end
      bus_xfer(3'b100, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("ovf_w1c", tr_tsr_rdata, 8'h00);
      chk("ovf_clrpulse", {6'd0, tr_tsr_clear_flag}, PULSE_EN ? 8'h01 : 8'h00);
      @(negedge tr_clk);
      chk("ovf_clrpulse_end", {6'd0, tr_tsr_clear_flag}, 8'h00);

      // Set wins over simultaneous clear; write 0 is a no-op
      bus_xfer(3'b100, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("udf_setwins", tr_tsr_rdata, 8'h02);
      chk("udf_setwins_pulse", {6'd0, tr_tsr_clear_flag}, PULSE_EN ? 8'h02 : 8'h00);
      bus_xfer(3'b100, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("tsr_wr0", tr_tsr_rdata, 8'h02);
      chk("tsr_wr0_pulse", {6'd0, tr_tsr_clear_flag}, 8'h00);
      pulse_events(1'b1, 1'b0);
      chk("both_set", tr_tsr_rdata, 8'h03);
      bus_xfer(3'b100, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("tsr_read_noclr", tr_tsr_rdata, 8'h03);
      bus_xfer(3'b100, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("tsr_noready", tr_tsr_rdata, 8'h03);
      chk("tsr_noready_pulse", {6'd0, tr_tsr_clear_flag}, 8'h00);

      // Non-one-hot and empty selects write nothing
      bus_xfer(3'b000, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_all("sel000", 8'h5A, 8'h91, 8'h03);
      bus_xfer(3'b011, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_all("sel011", 8'h5A, 8'h91, 8'h03);
      bus_xfer(3'b110, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_all("sel110", 8'h5A, 8'h91, 8'h03);
      bus_xfer(3'b111, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_all("sel111", 8'h5A, 8'h91, 8'h03);
      chk("sel_pulse", {6'd0, tr_tsr_clear_flag}, 8'h00);

      // UDF only clear
      bus_xfer(3'b100, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("udf_w1c", tr_tsr_rdata, 8'h01);
      chk("udf_w1c_pulse", {6'd0, tr_tsr_clear_flag}, PULSE_EN ? 8'h02 : 8'h00);

      // Asynchronous reset in the middle of a transfer
      @(negedge tr_clk);
      tr_sel = 1'b1; tr_write = 1'b1; tr_enable = 1'b1; tr_ready = 1'b1;
      tr_selected_reg = 3'b001; tr_wdata = 8'hEE;
      #2 tr_reset_n = 1'b0;
      #1;
      chk_all("async_rst", 8'h00, 8'h00, 8'h00);
      chk("async_rst_en", {7'd0, tr_tcr_en}, 8'h00);
      @(negedge tr_clk);
      chk("rst_hold_tdr", tr_tdr_rdata, 8'h00);
      tr_reset_n = 1'b1;
      bus_idle();

      // First write after reset is accepted
      bus_xfer(3'b010, 8'h21, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("post_rst_tcr", tr_tcr_rdata, 8'h21);
      chk("post_rst_tdr", tr_tdr_rdata, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
